// File: rtl/mux_key_with_default.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : mux_key_with_default                                       |
// | Description : Key-to-value lookup multiplexer over NR_KEY packed         |
// |               {key, data} pairs, with a caller-supplied default on miss, |
// |               a zero-latency result and a one-cycle registered copy.     |
// | Option      : MUX_KEY_PRIORITY_EN - when defined, the lowest-index match |
// |               wins; otherwise the data of all matches is OR-ed.          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module mux_key_with_default #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [KEY_LEN-1:0]                     key,
  input  logic [DATA_LEN-1:0]                    default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut,
  output logic [DATA_LEN-1:0]                    out,
  output logic                                   hit,
  output logic                                   multi_hit,
  output logic [DATA_LEN-1:0]                    out_q,
  output logic                                   hit_q
);

  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  w_key  [NR_KEY];
  logic [DATA_LEN-1:0] w_data [NR_KEY];
  logic [NR_KEY-1:0]   w_match;
  logic [DATA_LEN-1:0] w_sel;
  logic                w_seen;
  logic                w_multi;

  // Entry i sits at lut[(i+1)*PAIR_LEN-1 : i*PAIR_LEN], key in the upper bits.
  for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
    assign w_key[gi]   = lut[gi*PAIR_LEN+DATA_LEN +: KEY_LEN];
    assign w_data[gi]  = lut[gi*PAIR_LEN +: DATA_LEN];
    assign w_match[gi] = (w_key[gi] == key);
  end

  // Select the data of matching entries and detect a second match.
  always_comb begin
    w_sel   = '0;
    w_seen  = 1'b0;
    w_multi = 1'b0;
    for (int i = 0; i < NR_KEY; i++) begin
`ifdef MUX_KEY_PRIORITY_EN
      // Walk from entry 0 upward; the first match locks the selection.
      if (w_match[i] && !w_seen) begin
        w_sel = w_data[i];
      end
`else
      // Flat AND-OR: every matching entry contributes, no priority chain.
      w_sel = w_sel | (w_data[i] & {DATA_LEN{w_match[i]}});
`endif
      if (w_match[i] && w_seen) begin
        w_multi = 1'b1;
      end
      if (w_match[i]) begin
        w_seen = 1'b1;
      end
    end
  end

  assign hit       = |w_match;
  assign multi_hit = w_multi;
  assign out       = hit ? w_sel : default_out;

  // Registered copy for timing-critical consumers; cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      hit_q <= 1'b0;
    end else begin
      out_q <= out;
      hit_q <= hit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_key_with_default.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_mux_key_with_default                                    |
// | Description : Scoreboard bench for mux_key_with_default (4 x {12b,2b}). |
// |               Honours MUX_KEY_PRIORITY_EN in its reference model.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_mux_key_with_default;

  localparam int NR_KEY   = 4;
  localparam int KEY_LEN  = 12;
  localparam int DATA_LEN = 2;
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [KEY_LEN-1:0]          key = '0;
  logic [DATA_LEN-1:0]         default_out = '0;
  logic [NR_KEY*PAIR_LEN-1:0]  lut = '0;
  logic [DATA_LEN-1:0]         out;
  logic                        hit;
  logic                        multi_hit;
  logic [DATA_LEN-1:0]         out_q;
  logic                        hit_q;

  mux_key_with_default #(
    .NR_KEY   (NR_KEY),
    .KEY_LEN  (KEY_LEN),
    .DATA_LEN (DATA_LEN)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .key         (key),
    .default_out (default_out),
    .lut         (lut),
    .out         (out),
    .hit         (hit),
    .multi_hit   (multi_hit),
    .out_q       (out_q),
    .hit_q       (hit_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                  step;
    logic [DATA_LEN-1:0] o;
    logic                h;
    logic                m;
    logic [DATA_LEN-1:0] oq;
    logic                hq;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference table held as plain arrays, entry index = array index.
  logic [KEY_LEN-1:0]  tkey  [NR_KEY];
  logic [DATA_LEN-1:0] tdata [NR_KEY];

  logic [DATA_LEN-1:0] prev_out = '0;
  logic                prev_hit = 1'b0;
  logic                prev_rst = 1'b1;
  int                  step_no  = 0;

  logic [KEY_LEN-1:0]  pool [5];

  // Lookup rules: count matches; miss -> default; first match or OR of all.
  function automatic void model(input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] dflt,
                                output logic [DATA_LEN-1:0] o, output logic h, output logic m);
    int n;
    n = 0;
    o = '0;
    for (int i = 0; i < NR_KEY; i++) begin
      if (tkey[i] == k) begin
`ifdef MUX_KEY_PRIORITY_EN
        if (n == 0) o = tdata[i];
`else
        o = o | tdata[i];
`endif
        n++;
      end
    end
    h = (n > 0);
    m = (n > 1);
    if (!h) o = dflt;
  endfunction

  task automatic load_base_table();
    tkey[3] = 12'h300; tdata[3] = 2'b00;
    tkey[2] = 12'h305; tdata[2] = 2'b01;
    tkey[1] = 12'h342; tdata[1] = 2'b10;
    tkey[0] = 12'h341; tdata[0] = 2'b11;
  endtask

  // One cycle of stimulus: drive after the edge, push the expected response.
  task automatic do_step(input logic r, input logic [KEY_LEN-1:0] k, input logic [DATA_LEN-1:0] d);
    exp_t                e;
    logic [DATA_LEN-1:0] o;
    logic                h;
    logic                m;
    @(posedge clk);
    #1;
    rst         = r;
    key         = k;
    default_out = d;
    for (int i = 0; i < NR_KEY; i++) lut[i*PAIR_LEN +: PAIR_LEN] = {tkey[i], tdata[i]};
    model(k, d, o, h, m);
    e.step = step_no;
    e.o    = o;
    e.h    = h;
    e.m    = m;
    e.oq   = (r || prev_rst) ? '0 : prev_out;
    e.hq   = (r || prev_rst) ? 1'b0 : prev_hit;
    sb.push_back(e);
    prev_out = o;
    prev_hit = h;
    prev_rst = r;
    step_no++;
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out",       e.step, 32'(out),       32'(e.o));
        chk("hit",       e.step, 32'(hit),       32'(e.h));
        chk("multi_hit", e.step, 32'(multi_hit), 32'(e.m));
        chk("out_q",     e.step, 32'(out_q),     32'(e.oq));
        chk("hit_q",     e.step, 32'(hit_q),     32'(e.hq));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog step=%0d got=timeout want=finish", step_no);
    $fatal(1, "watchdog");
  end

  initial begin
    pool[0] = 12'h300; pool[1] = 12'h305; pool[2] = 12'h342;
    pool[3] = 12'h341; pool[4] = 12'h123;
    load_base_table();

    // Reset state, then every present key.
    do_step(1'b1, 12'h300, 2'b00);
    do_step(1'b0, 12'h300, 2'b00);
    do_step(1'b0, 12'h305, 2'b00);
    do_step(1'b0, 12'h342, 2'b00);
    do_step(1'b0, 12'h341, 2'b00);
    // Miss with two defaults.
    do_step(1'b0, 12'h123, 2'b10);
    do_step(1'b0, 12'h123, 2'b00);
    // Registered path follows one edge behind.
    do_step(1'b0, 12'h305, 2'b00);
    do_step(1'b0, 12'h341, 2'b00);
    do_step(1'b0, 12'h341, 2'b00);
    do_step(1'b0, 12'h123, 2'b00);
    do_step(1'b0, 12'h123, 2'b00);
    // Mid-operation reset, held across edges, then release.
    do_step(1'b0, 12'h341, 2'b00);
    do_step(1'b0, 12'h341, 2'b00);
    do_step(1'b1, 12'h341, 2'b00);
    do_step(1'b1, 12'h341, 2'b00);
    do_step(1'b0, 12'h341, 2'b00);
    do_step(1'b0, 12'h305, 2'b00);
    do_step(1'b0, 12'h305, 2'b00);
    // Duplicate keys on entries 0 and 2.
    tkey[0] = 12'h341; tdata[0] = 2'b01;
    tkey[2] = 12'h341; tdata[2] = 2'b10;
    do_step(1'b0, 12'h341, 2'b00);
    do_step(1'b0, 12'h300, 2'b00);
    do_step(1'b0, 12'h341, 2'b11);
    do_step(1'b0, 12'h305, 2'b10);

    // Randomised tables drawn from a small key pool to force hits and duplicates.
    for (int n = 0; n < 240; n++) begin
      if (n % 8 == 0) begin
        for (int i = 0; i < NR_KEY; i++) begin
          tkey[i]  = pool[$urandom_range(4, 0)];
          tdata[i] = DATA_LEN'($urandom);
        end
      end
      do_step(($urandom_range(19, 0) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(5, 0) == 5) ? KEY_LEN'($urandom) : pool[$urandom_range(4, 0)],
              DATA_LEN'($urandom));
    end

    repeat (3) @(negedge clk);
    #1;
    chk("drain", step_no, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
